// File: rtl/risc_v_regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : risc_v_regfile_sb_if
//  Description : Bus between decode / write-back and the register file with
//                scoreboard. Carries read addresses and data, the write-back
//                port, the issue port and the scoreboard summary outputs.
//  Ports       : rd_addr/rd_data/rd_busy  - NRP read ports (flattened)
//                wr_en/wr_addr/wr_data    - write-back port
//                iss_en/iss_addr          - destination of issuing instruction
//                any_busy/busy_cnt        - registered scoreboard summary
//  Revision    : 1.0 - initial release
// ============================================================================
interface risc_v_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
);
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                any_busy;
    logic [AW:0]         busy_cnt;

    // Decode / write-back side.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, any_busy, busy_cnt
    );

    // Register file side.
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, any_busy, busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/risc_v_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : risc_v_regfile_sb
//  Description : Parametrised RISC-V integer register file with NRP
//                combinational read ports, write-first bypass and a
//                per-register busy scoreboard for RAW hazard detection.
//  Ports       : clk   - clock, all state updates on the rising edge
//                clrn  - synchronous active-high reset
//                bus   - slave side of risc_v_regfile_sb_if (reads, write-
//                        back, issue, scoreboard summary)
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_v_regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  wire logic           clk,
    input  wire logic           clrn,
    risc_v_regfile_sb_if.slave  bus
);

    localparam logic [XLEN-1:0] c_ZERO = '0;

    // x0 has no storage: arrays start at index 1.
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic            any_busy_q;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;

    // Full-range views with x0 hard-wired to zero / not busy, so a read
    // address can index them directly without an out-of-range access.
    logic [XLEN-1:0] w_reg_view  [NREG];
    logic [NREG-1:0] w_busy_view;

    always_comb begin
        w_reg_view[0] = c_ZERO;
        for (int r = 1; r < NREG; r++) begin
            w_reg_view[r] = regs_q[r];
        end
        w_busy_view = {busy_q, 1'b0};
    end

    // ------------------------------------------------------------------
    // Busy next state: issue sets, write-back clears, set wins so that a
    // new producer supersedes the one completing in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = '0;
        for (int r = 1; r < NREG; r++) begin
            if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset takes priority over write and issue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= c_ZERO;
            end
            busy_q     <= '0;
            any_busy_q <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
                    regs_q[r] <= bus.wr_data;
                end
            end
            busy_q     <= busy_d;
            any_busy_q <= |busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.any_busy = any_busy_q;
    assign bus.busy_cnt = busy_cnt_q;

    // ------------------------------------------------------------------
    // Read ports: independent, combinational, write-first bypass.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_nz;
        logic          w_wr_hit;
        logic          w_iss_hit;

        assign w_addr    = bus.rd_addr[i*AW +: AW];
        assign w_nz      = (w_addr != '0);
        assign w_wr_hit  = bus.wr_en  && (bus.wr_addr  == w_addr);
        assign w_iss_hit = bus.iss_en && (bus.iss_addr == w_addr);

        assign bus.rd_data[i*XLEN +: XLEN] =
            !w_nz    ? c_ZERO :
            w_wr_hit ? bus.wr_data : w_reg_view[w_addr];

        // A completing producer makes the bypassed value valid, unless a
        // new producer for the same register issues in this cycle.
        assign bus.rd_busy[i] =
            !w_nz                      ? 1'b0 :
            (w_wr_hit && !w_iss_hit)   ? 1'b0 : w_busy_view[w_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_risc_v_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_v_regfile_sb
//  Description : Self-checking bench. Instance A (default parameters) gets
//                directed scenarios; instance B (NRP=4, XLEN=64) gets random
//                traffic compared against a behavioural register/scoreboard
//                model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_v_regfile_sb;

    localparam int c_NREG = 32;
    localparam int c_AW   = 5;

    logic clk;
    logic clrn_a;
    logic clrn_b;

    int n_tests = 0;
    int n_fail  = 0;

    risc_v_regfile_sb_if #(.XLEN(32), .NREG(c_NREG), .AW(c_AW), .NRP(2)) bus_a ();
    risc_v_regfile_sb_if #(.XLEN(64), .NREG(c_NREG), .AW(c_AW), .NRP(4)) bus_b ();

    risc_v_regfile_sb #(.XLEN(32), .NREG(c_NREG), .AW(c_AW), .NRP(2)) dut_a (
        .clk  (clk),
        .clrn (clrn_a),
        .bus  (bus_a.slave)
    );

    risc_v_regfile_sb #(.XLEN(64), .NREG(c_NREG), .AW(c_AW), .NRP(4)) dut_b (
        .clk  (clk),
        .clrn (clrn_b),
        .bus  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.wr_en    = 1'b0;
        bus_a.wr_addr  = '0;
        bus_a.wr_data  = '0;
        bus_a.iss_en   = 1'b0;
        bus_a.iss_addr = '0;
    endtask

    task automatic port_a(input int p, input int addr);
        bus_a.rd_addr[p*c_AW +: c_AW] = c_AW'(addr);
    endtask

    // ------------------------------------------------------------------
    // Reference model for instance B
    // ------------------------------------------------------------------
    logic [63:0] m_reg  [c_NREG];
    bit          m_busy [c_NREG];

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < c_NREG; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Directed tests on instance A
    // ------------------------------------------------------------------
    task automatic run_directed();
        clrn_a = 1'b1;
        idle_a();
        bus_a.rd_addr = '0;
        tick();
        tick();
        clrn_a = 1'b0;
        port_a(0, 5);
        port_a(1, 9);
        #1;
        check_val("rst_rd0", 64'(bus_a.rd_data[31:0]), 64'h0);
        check_val("rst_rd1", 64'(bus_a.rd_data[63:32]), 64'h0);
        check_val("rst_busy", 64'(bus_a.rd_busy), 64'h0);
        check_val("rst_cnt", 64'(bus_a.busy_cnt), 64'h0);
        check_val("rst_any", 64'(bus_a.any_busy), 64'h0);

        // Write x5, then reset clears it.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hDEADBEEF;
        tick();
        idle_a();
        #1;
        check_val("wr_x5", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
        clrn_a = 1'b1;
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd9;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd9; bus_a.wr_data = 32'h123;
        tick();
        clrn_a = 1'b0;
        idle_a();
        #1;
        check_val("rst_x5", 64'(bus_a.rd_data[31:0]), 64'h0);
        check_val("rst_ign_wr", 64'(bus_a.rd_data[63:32]), 64'h0);
        check_val("rst_ign_iss", 64'(bus_a.rd_busy[1]), 64'h0);
        check_val("rst_cnt2", 64'(bus_a.busy_cnt), 64'h0);

        // x0 is hard-wired.
        port_a(0, 0);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'hFFFFFFFF;
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd0;
        #1;
        check_val("x0_same", 64'(bus_a.rd_data[31:0]), 64'h0);
        check_val("x0_busy_same", 64'(bus_a.rd_busy[0]), 64'h0);
        tick();
        idle_a();
        #1;
        check_val("x0_after", 64'(bus_a.rd_data[31:0]), 64'h0);
        check_val("x0_cnt", 64'(bus_a.busy_cnt), 64'h0);
        check_val("x0_any", 64'(bus_a.any_busy), 64'h0);

        // Bypass.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h11;
        tick();
        port_a(0, 7);
        port_a(1, 7);
        bus_a.wr_data = 32'h22;
        #1;
        check_val("byp_p0", 64'(bus_a.rd_data[31:0]), 64'h22);
        check_val("byp_p1", 64'(bus_a.rd_data[63:32]), 64'h22);
        tick();
        idle_a();
        #1;
        check_val("byp_p0_after", 64'(bus_a.rd_data[31:0]), 64'h22);
        check_val("byp_p1_after", 64'(bus_a.rd_data[63:32]), 64'h22);

        // Scoreboard issue / write-back.
        port_a(0, 3);
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd3;
        tick();
        idle_a();
        #1;
        check_val("sb_busy", 64'(bus_a.rd_busy[0]), 64'h1);
        check_val("sb_cnt1", 64'(bus_a.busy_cnt), 64'h1);
        check_val("sb_any1", 64'(bus_a.any_busy), 64'h1);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h55;
        #1;
        check_val("sb_wb_busy", 64'(bus_a.rd_busy[0]), 64'h0);
        check_val("sb_wb_data", 64'(bus_a.rd_data[31:0]), 64'h55);
        check_val("sb_wb_cnt_pre", 64'(bus_a.busy_cnt), 64'h1);
        tick();
        idle_a();
        #1;
        check_val("sb_cnt0", 64'(bus_a.busy_cnt), 64'h0);
        check_val("sb_busy0", 64'(bus_a.rd_busy[0]), 64'h0);

        // Issue and write-back of the same register: set wins.
        port_a(0, 4);
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd4;
        tick();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h99;
        #1;
        check_val("sim_busy_same", 64'(bus_a.rd_busy[0]), 64'h1);
        tick();
        idle_a();
        #1;
        check_val("sim_data", 64'(bus_a.rd_data[31:0]), 64'h99);
        check_val("sim_busy", 64'(bus_a.rd_busy[0]), 64'h1);
        check_val("sim_cnt", 64'(bus_a.busy_cnt), 64'h1);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h98;
        tick();
        idle_a();

        // Fill the scoreboard, then drain it.
        for (int r = 1; r < c_NREG; r++) begin
            bus_a.iss_en = 1'b1; bus_a.iss_addr = c_AW'(r);
            tick();
        end
        idle_a();
        #1;
        check_val("fill_cnt", 64'(bus_a.busy_cnt), 64'd31);
        check_val("fill_any", 64'(bus_a.any_busy), 64'h1);
        for (int r = 1; r < c_NREG; r++) begin
            bus_a.wr_en = 1'b1; bus_a.wr_addr = c_AW'(r);
            bus_a.wr_data = 32'(r * 32'h01010101);
            tick();
        end
        idle_a();
        #1;
        check_val("drain_cnt", 64'(bus_a.busy_cnt), 64'h0);
        check_val("drain_any", 64'(bus_a.any_busy), 64'h0);
        port_a(0, 31);
        port_a(1, 17);
        #1;
        check_val("drain_x31", 64'(bus_a.rd_data[31:0]), 64'(32'(31 * 32'h01010101)));
        check_val("drain_x17", 64'(bus_a.rd_data[63:32]), 64'(32'(17 * 32'h01010101)));
    endtask

    // ------------------------------------------------------------------
    // Random traffic on instance B
    // ------------------------------------------------------------------
    task automatic run_random(input int n_cycles);
        logic [4:0]  a;
        logic [63:0] exp_d;
        bit          exp_b;
        clrn_b = 1'b1;
        bus_b.wr_en = 1'b0; bus_b.iss_en = 1'b0;
        bus_b.wr_addr = '0; bus_b.iss_addr = '0; bus_b.wr_data = '0;
        bus_b.rd_addr = '0;
        tick();
        for (int r = 0; r < c_NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
        for (int c = 0; c < n_cycles; c++) begin
            clrn_b         = ($urandom_range(0, 63) == 0);
            bus_b.wr_en    = ($urandom_range(0, 2) != 0);
            bus_b.wr_addr  = 5'($urandom_range(0, 31));
            bus_b.wr_data  = {32'($urandom), 32'($urandom)};
            bus_b.iss_en   = ($urandom_range(0, 2) != 0);
            // Bias the issue address toward the write address to exercise
            // same-register set/clear collisions.
            bus_b.iss_addr = ($urandom_range(0, 3) == 0) ? bus_b.wr_addr
                                                         : 5'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 3))
                    0:       bus_b.rd_addr[p*5 +: 5] = bus_b.wr_addr;
                    1:       bus_b.rd_addr[p*5 +: 5] = bus_b.iss_addr;
                    default: bus_b.rd_addr[p*5 +: 5] = 5'($urandom_range(0, 31));
                endcase
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                a = bus_b.rd_addr[p*5 +: 5];
                if (a == 0) begin
                    exp_d = '0;
                    exp_b = 1'b0;
                end else if (bus_b.wr_en && bus_b.wr_addr == a) begin
                    exp_d = bus_b.wr_data;
                    exp_b = (bus_b.iss_en && bus_b.iss_addr == a) ? m_busy[a] : 1'b0;
                end else begin
                    exp_d = m_reg[a];
                    exp_b = m_busy[a];
                end
                check_val($sformatf("rnd_data_p%0d", p), bus_b.rd_data[p*64 +: 64], exp_d);
                check_val($sformatf("rnd_busy_p%0d", p), 64'(bus_b.rd_busy[p]), 64'(exp_b));
            end
            check_val("rnd_cnt", 64'(bus_b.busy_cnt), 64'(model_count()));
            check_val("rnd_any", 64'(bus_b.any_busy), 64'(model_count() != 0));
            // Model the clock edge.
            if (clrn_b) begin
                for (int r = 0; r < c_NREG; r++) begin
                    m_reg[r]  = '0;
                    m_busy[r] = 1'b0;
                end
            end else begin
                if (bus_b.wr_en && bus_b.wr_addr != 0) begin
                    m_reg[bus_b.wr_addr]  = bus_b.wr_data;
                    m_busy[bus_b.wr_addr] = 1'b0;
                end
                if (bus_b.iss_en && bus_b.iss_addr != 0) begin
                    m_busy[bus_b.iss_addr] = 1'b1;
                end
            end
            tick();
        end
    endtask

    initial begin
        clrn_a = 1'b1;
        clrn_b = 1'b1;
        bus_b.rd_addr = '0;
        bus_b.wr_en = 1'b0; bus_b.iss_en = 1'b0;
        bus_b.wr_addr = '0; bus_b.iss_addr = '0; bus_b.wr_data = '0;
        run_directed();
        run_random(600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_v_regfile_sb.md
Name: risc_v_regfile_sb

Overview:
Parametrised RISC-V integer register file for the pipelined core, replacing the fixed 2-read/1-write, 32x32 file.
- Adds a configurable number of read ports.
- Adds write-to-read bypass, so a result written in a cycle is visible on the read ports in that same cycle.
- Adds a per-register busy scoreboard. Decode uses it to detect RAW hazards against in-flight producers.
- Sits between decode (reads, issue) and write-back (write, busy clear).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers including x0 (power of two, >=2)
AW, 5, register address width (log2(NREG))
NRP, 2, number of read ports (1..4)

Ports:
clk  input  1  clock; all state updates on rising edge
clrn  input  1  reset: synchronous, active-high (clrn=1 at a rising edge resets)
rd_addr  input  NRP*AW  read addresses; port i uses bits [i*AW +: AW]
rd_data  output  NRP*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rd_busy  output  NRP  busy flag of the register addressed by each read port
wr_en  input  1  write-back enable
wr_addr  input  AW  write-back destination
wr_data  input  XLEN  write-back data
iss_en  input  1  an instruction with a destination register issues this cycle
iss_addr  input  AW  destination of the issuing instruction
any_busy  output  1  OR of all busy bits (drain / fence indication)
busy_cnt  output  AW+1  number of busy registers

Behaviour:
- Storage: regs[1..NREG-1] of XLEN bits; busy[1..NREG-1].
  - x0 has no storage and no busy bit.
  - x0 reads as 0 and is never busy.
- Reset (clrn=1 at a clock edge): all regs := 0, all busy := 0.
  - While clrn=1 the edge ignores wr_en and iss_en.
  - After the reset edge: rd_data=0, rd_busy=0, any_busy=0, busy_cnt=0.
  - Reset mid-operation discards pending busy state unconditionally.
- Write: on an edge with wr_en=1, wr_addr!=0, clrn=0: regs[wr_addr] := wr_data.
  - wr_addr=0 is a no-op for both data and busy.
- Read (combinational, zero latency), per port i with address a = rd_addr[i]:
  - a=0: data 0.
  - else if wr_en=1 and wr_addr=a: data = wr_data (bypass, write-first).
  - else: data = regs[a].
  - All ports are independent; two or more ports may read the same address.
- rd_busy[i], combinational:
  - a=0: 0.
  - else if wr_en=1 and wr_addr=a and not (iss_en=1 and iss_addr=a): 0. The producer completes this cycle, so bypassed data is valid.
  - else: busy[a].
- Busy update at a clock edge (clrn=0), per register r!=0:
  - set when iss_en=1 and iss_addr=r.
  - else clear when wr_en=1 and wr_addr=r.
  - else hold.
  - Set and clear of the same register in the same cycle: set wins, because the new producer supersedes.
  - iss_en with iss_addr=0: no effect.
- Re-issue to an already-busy register: stays busy. There is no count per register; the last writer clears it. Decode guarantees in-order write-back (WAW is not the block's concern).
- Write to a non-busy register: data written, busy stays 0. This is legal, e.g. after a flush.
- any_busy and busy_cnt are registered state. They reflect busy bits after the last edge, not same-cycle bypass.
  - busy_cnt is the popcount of busy[1..NREG-1]; maximum NREG-1, which fits in AW+1 bits.
- No X on any output after reset, even for registers never written.

Test Plan:
- Reset: write x5=0xDEADBEEF, assert clrn one cycle -> rd_addr0=5 reads 0x00000000; busy_cnt=0, any_busy=0.
- x0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; iss_en=1, iss_addr=0 -> port0 addr 0 reads 0 (also in the same cycle); rd_busy=0; busy_cnt stays 0.
- Bypass: regs[7]=0x11; in one cycle wr_en=1, wr_addr=7, wr_data=0x22, port0=7, port1=7 -> both ports read 0x22 combinationally; after the edge, reads return 0x22.
- Scoreboard: issue x3 -> next cycle rd_busy(port0=3)=1, busy_cnt=1. Write-back x3=0x55 -> same cycle rd_busy=0 with data 0x55; after the edge, busy_cnt=0.
- Simultaneous events: x4 busy; same cycle iss_en (x4) and wr_en (x4, 0x99) -> after the edge, x4 reads 0x99, busy=1, busy_cnt unchanged at 1.
- Fill: issue x1..x31 on consecutive cycles -> busy_cnt reaches 31 and any_busy=1. Write back all -> busy_cnt=0, any_busy=0. Repeat with NRP=4, XLEN=64, with random address/data traffic checked against a reference model.
